// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 4-stage IF/DOF/EX/WB core.
// It keeps a small destination scoreboard for the EX and WB stages and checks
// it against the DOF operand addresses. From the result it picks one action
// per cycle: RUN, STALL, FLUSH or FREEZE. That action drives the PC/IR
// enables, bubble insertion, the stall/flush counters and a stall watchdog.
module pipe_hazard_ctrl #(
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dof_valid,
  input  logic [2:0]       dof_aa,
  input  logic [2:0]       dof_ba,
  input  logic             dof_ma,
  input  logic             dof_mb,
  input  logic             dof_rw,
  input  logic [2:0]       dof_da,
  input  logic             br_taken,
  input  logic             mem_wait,
  output logic             pc_en,
  output logic             ir_en,
  output logic             ir_clr,
  output logic             bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             err_stall
);

  typedef enum logic [1:0] {
    ACT_RUN    = 2'd0,
    ACT_STALL  = 2'd1,
    ACT_FLUSH  = 2'd2,
    ACT_FREEZE = 2'd3
  } act_e;

  // One pending register-file write: write flag plus destination address.
  typedef struct packed {
    logic       rw;
    logic [2:0] da;
  } sb_entry_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       RUN_ONE     = 4'd1;
  localparam logic [3:0]       MAX_STALL_W = 4'(MAX_STALL);

  sb_entry_t        r_ex_e;
  sb_entry_t        r_wb_e;
  act_e             r_state;
  logic [3:0]       r_run_len;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             r_err_stall;

  act_e             w_act;
  sb_entry_t        w_dof_e;
  logic             w_ex_live;
  logic             w_wb_live;
  logic             w_hz_a;
  logic             w_hz_b;
  logic             w_hazard;
  logic [3:0]       w_run_nxt;

  // R0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic live(input sb_entry_t e);
    return e.rw && (e.da != 3'd0);
  endfunction

  // With a write-before-read register file the WB result is already visible
  // to DOF, so the WB entry only takes part in the compare when that bypass is absent.
  assign w_ex_live = live(r_ex_e);
  assign w_wb_live = (WB_BYPASS == 0) && live(r_wb_e);

  assign w_hz_a = dof_valid && !dof_ma &&
                  ((w_ex_live && (r_ex_e.da == dof_aa)) ||
                   (w_wb_live && (r_wb_e.da == dof_aa)));
  assign w_hz_b = dof_valid && !dof_mb &&
                  ((w_ex_live && (r_ex_e.da == dof_ba)) ||
                   (w_wb_live && (r_wb_e.da == dof_ba)));
  assign w_hazard = w_hz_a || w_hz_b;

  // An invalid DOF slot enters EX as a non-writing entry.
  assign w_dof_e.rw = dof_valid && dof_rw;
  assign w_dof_e.da = dof_da;

  // The stall run length saturates at 15, which is the top of the MAX_STALL range.
  assign w_run_nxt = (r_run_len == 4'hF) ? r_run_len : (r_run_len + RUN_ONE);

  // Choose this cycle's action. Memory wait wins, then branch, then hazard.
  always_comb begin
    // NOTE: assigning a default first means every path drives w_act,
    // so synthesis infers no latch.
    w_act = ACT_RUN;
    if (mem_wait) begin
      w_act = ACT_FREEZE;
    end else if (br_taken) begin
      w_act = ACT_FLUSH;
    end else if (w_hazard) begin
      w_act = ACT_STALL;
    end
  end

  // Decode the action into pipeline enables. Reset pushes NOPs into both latches.
  always_comb begin
    pc_en  = 1'b0;
    ir_en  = 1'b0;
    ir_clr = 1'b0;
    bubble = 1'b0;
    if (rst) begin
      ir_clr = 1'b1;
      bubble = 1'b1;
    end else begin
      case (w_act)
        ACT_RUN: begin
          pc_en = 1'b1;
          ir_en = 1'b1;
        end
        ACT_STALL: begin
          bubble = 1'b1;
        end
        ACT_FLUSH: begin
          pc_en  = 1'b1;
          ir_en  = 1'b1;
          ir_clr = 1'b1;
          bubble = 1'b1;
        end
        ACT_FREEZE: begin
          pc_en = 1'b0;
        end
      endcase
    end
  end

  // Advance the scoreboard, state, counters and watchdog on each edge.
  always_ff @(posedge clk) begin
    // NOTE: all state updates are non-blocking. Every register then samples
    // the pre-edge values, whatever order the statements appear in.
    if (rst) begin
      r_ex_e      <= '0;
      r_wb_e      <= '0;
      r_state     <= ACT_RUN;
      r_run_len   <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_err_stall <= 1'b0;
    end else begin
      r_state <= w_act;
      case (w_act)
        ACT_RUN: begin
          r_ex_e    <= w_dof_e;
          r_wb_e    <= r_ex_e;
          r_run_len <= '0;
        end
        ACT_STALL: begin
          r_ex_e    <= '0;
          r_wb_e    <= r_ex_e;
          r_run_len <= w_run_nxt;
          if (r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
          end
          if (w_run_nxt >= MAX_STALL_W) begin
            r_err_stall <= 1'b1;
          end
        end
        ACT_FLUSH: begin
          r_ex_e    <= '0;
          r_wb_e    <= r_ex_e;
          r_run_len <= '0;
          if (r_flush_cnt != '1) begin
            r_flush_cnt <= r_flush_cnt + CNT_ONE;
          end
        end
        ACT_FREEZE: begin
          r_ex_e <= r_ex_e;
        end
      endcase
    end
  end

  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign err_stall = r_err_stall;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl. Two instances receive the same inputs.
// "byp" uses WB_BYPASS=1, CNT_W=16 and MAX_STALL=4. "nob" uses WB_BYPASS=0,
// CNT_W=3 and MAX_STALL=2, so its watchdog and saturation are reachable.
// A directed table runs first, then hand-written corner sequences, then
// random stimulus checked every cycle against an in-flight-write model.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       dof_valid;
  logic [2:0] dof_aa;
  logic [2:0] dof_ba;
  logic       dof_ma;
  logic       dof_mb;
  logic       dof_rw;
  logic [2:0] dof_da;
  logic       br_taken;
  logic       mem_wait;

  logic        pc_en0, ir_en0, ir_clr0, bubble0, err0;
  logic [1:0]  state0;
  logic [15:0] stall_cnt0, flush_cnt0;
  logic        pc_en1, ir_en1, ir_clr1, bubble1, err1;
  logic [1:0]  state1;
  logic [2:0]  stall_cnt1, flush_cnt1;

  int n_checks = 0;
  int n_errors = 0;

  pipe_hazard_ctrl #(.WB_BYPASS(1), .CNT_W(16), .MAX_STALL(4)) u_byp (
    .clk(clk), .rst(rst), .dof_valid(dof_valid), .dof_aa(dof_aa), .dof_ba(dof_ba),
    .dof_ma(dof_ma), .dof_mb(dof_mb), .dof_rw(dof_rw), .dof_da(dof_da),
    .br_taken(br_taken), .mem_wait(mem_wait), .pc_en(pc_en0), .ir_en(ir_en0),
    .ir_clr(ir_clr0), .bubble(bubble0), .state(state0), .stall_cnt(stall_cnt0),
    .flush_cnt(flush_cnt0), .err_stall(err0)
  );

  pipe_hazard_ctrl #(.WB_BYPASS(0), .CNT_W(3), .MAX_STALL(2)) u_nob (
    .clk(clk), .rst(rst), .dof_valid(dof_valid), .dof_aa(dof_aa), .dof_ba(dof_ba),
    .dof_ma(dof_ma), .dof_mb(dof_mb), .dof_rw(dof_rw), .dof_da(dof_da),
    .br_taken(br_taken), .mem_wait(mem_wait), .pc_en(pc_en1), .ir_en(ir_en1),
    .ir_clr(ir_clr1), .bubble(bubble1), .state(state1), .stall_cnt(stall_cnt1),
    .flush_cnt(flush_cnt1), .err_stall(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish (act=running req=finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. For each instance it keeps the destination register of
  // the write still in flight one and two stages after DOF (0 = no write).
  // It also keeps the visible state code, counters, watchdog flag and run length.
  int m_dst   [2][2];
  int m_state [2];
  int m_stall [2];
  int m_flush [2];
  int m_err   [2];
  int m_run   [2];
  bit m_known [2];

  // 0 RUN, 1 STALL, 2 FLUSH, 3 FREEZE, from the priority rules.
  function automatic int exp_act(input int k);
    int depth;
    bit hz;
    depth = (k == 0) ? 1 : 2;
    hz = 1'b0;
    if (mem_wait) return 3;
    if (br_taken) return 2;
    if (dof_valid) begin
      for (int i = 0; i < depth; i++) begin
        if (m_dst[k][i] != 0) begin
          if (!dof_ma && m_dst[k][i] == int'(dof_aa)) hz = 1'b1;
          if (!dof_mb && m_dst[k][i] == int'(dof_ba)) hz = 1'b1;
        end
      end
    end
    return hz ? 1 : 0;
  endfunction

  function automatic void model_update(input int k);
    int a;
    int cmax;
    int maxs;
    a = exp_act(k);
    cmax = (k == 0) ? 65535 : 7;
    maxs = (k == 0) ? 4 : 2;
    if (rst) begin
      m_dst[k][0] = 0; m_dst[k][1] = 0;
      m_state[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_err[k] = 0; m_run[k] = 0;
      m_known[k] = 1'b1;
      return;
    end
    m_state[k] = a;
    if (a == 3) return;
    m_dst[k][1] = m_dst[k][0];
    m_dst[k][0] = 0;
    if (a == 0) begin
      if (dof_valid && dof_rw) m_dst[k][0] = int'(dof_da);
      m_run[k] = 0;
    end else if (a == 2) begin
      if (m_flush[k] < cmax) m_flush[k]++;
      m_run[k] = 0;
    end else begin
      if (m_stall[k] < cmax) m_stall[k]++;
      if (m_run[k] < 15) m_run[k]++;
      if (m_run[k] >= maxs) m_err[k] = 1;
    end
  endfunction

  task automatic model_check(input int k, input logic pc, input logic ir, input logic clr,
                             input logic bub, input logic [1:0] st, input logic [31:0] sc,
                             input logic [31:0] fc, input logic err);
    int a;
    string p;
    p = (k == 0) ? "byp" : "nob";
    if (rst) begin
      check({p, " rst pc_en"}, 32'(pc), 32'd0);
      check({p, " rst ir_en"}, 32'(ir), 32'd0);
      check({p, " rst ir_clr"}, 32'(clr), 32'd1);
      check({p, " rst bubble"}, 32'(bub), 32'd1);
    end else begin
      a = exp_act(k);
      check({p, " pc_en"}, 32'(pc), 32'((a == 0) || (a == 2)));
      if (a != 2) check({p, " ir_en"}, 32'(ir), 32'(a == 0));
      check({p, " ir_clr"}, 32'(clr), 32'(a == 2));
      check({p, " bubble"}, 32'(bub), 32'((a == 1) || (a == 2)));
    end
    if (m_known[k]) begin
      check({p, " state"}, 32'(st), 32'(m_state[k]));
      check({p, " stall_cnt"}, sc, 32'(m_stall[k]));
      check({p, " flush_cnt"}, fc, 32'(m_flush[k]));
      check({p, " err_stall"}, 32'(err), 32'(m_err[k]));
    end
  endtask

  // Inputs are already applied. Let them settle, then compare both instances to the model.
  task automatic settle();
    #1;
    model_check(0, pc_en0, ir_en0, ir_clr0, bubble0, state0, 32'(stall_cnt0), 32'(flush_cnt0), err0);
    model_check(1, pc_en1, ir_en1, ir_clr1, bubble1, state1, 32'(stall_cnt1), 32'(flush_cnt1), err1);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] aa, input logic [2:0] ba, input logic ma,
                       input logic mb, input logic rw, input logic [2:0] da, input logic br,
                       input logic mw);
    dof_valid = v; dof_aa = aa; dof_ba = ba; dof_ma = ma; dof_mb = mb;
    dof_rw = rw; dof_da = da; br_taken = br; mem_wait = mw;
  endtask

  // Directed vector: inputs and the hand-derived outputs seen during that cycle.
  typedef struct {
    logic v; logic [2:0] aa; logic [2:0] ba; logic ma; logic mb; logic rw; logic [2:0] da;
    logic br; logic mw;
    int p0; int b0; int c0; int s0; int sc0; int fc0; int e0;
    int p1; int b1; int s1; int sc1; int e1;
  } vec_t;

  function automatic vec_t vec(input int v, aa, ba, ma, mb, rw, da, br, mw,
                               input int p0, b0, c0, s0, sc0, fc0, e0,
                               input int p1, b1, s1, sc1, e1);
    vec_t r;
    r.v = v[0]; r.aa = aa[2:0]; r.ba = ba[2:0]; r.ma = ma[0]; r.mb = mb[0];
    r.rw = rw[0]; r.da = da[2:0]; r.br = br[0]; r.mw = mw[0];
    r.p0 = p0; r.b0 = b0; r.c0 = c0; r.s0 = s0; r.sc0 = sc0; r.fc0 = fc0; r.e0 = e0;
    r.p1 = p1; r.b1 = b1; r.s1 = s1; r.sc1 = sc1; r.e1 = e1;
    return r;
  endfunction

  localparam int NV = 18;
  vec_t tbl [NV];

  initial begin
    //                v aa ba ma mb rw da br mw | byp: pc bub clr st sc fc err | nob: pc bub st sc err
    tbl[0]  = vec(1, 0, 0, 1, 1, 1, 3, 0, 0,  1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0); // write R3
    tbl[1]  = vec(1, 3, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0); // RAW on A
    tbl[2]  = vec(1, 3, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 1, 1, 0, 0,  0, 1, 1, 1, 0); // nob stalls again
    tbl[3]  = vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0,  1, 0, 1, 2, 1);
    tbl[4]  = vec(1, 0, 0, 1, 1, 1, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0,  1, 0, 0, 2, 1); // write R0
    tbl[5]  = vec(1, 0, 0, 0, 1, 1, 3, 0, 0,  1, 0, 0, 0, 1, 0, 0,  1, 0, 0, 2, 1); // read R0
    tbl[6]  = vec(1, 1, 3, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0,  1, 0, 0, 2, 1); // B=R3 masked
    tbl[7]  = vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0,  1, 0, 0, 2, 1);
    tbl[8]  = vec(1, 0, 0, 1, 1, 1, 5, 0, 0,  1, 0, 0, 0, 1, 0, 0,  1, 0, 0, 2, 1); // write R5
    tbl[9]  = vec(1, 5, 0, 0, 1, 0, 0, 1, 0,  1, 1, 1, 0, 1, 0, 0,  1, 1, 0, 2, 1); // branch + hazard
    tbl[10] = vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 2, 1, 1, 0,  1, 0, 2, 2, 1);
    tbl[11] = vec(1, 0, 0, 1, 1, 1, 6, 0, 0,  1, 0, 0, 0, 1, 1, 0,  1, 0, 0, 2, 1); // write R6
    tbl[12] = vec(1, 6, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 1, 1, 0,  0, 1, 0, 2, 1); // stall
    tbl[13] = vec(1, 6, 0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 1, 2, 1, 0,  0, 0, 1, 3, 1); // freeze x3
    tbl[14] = vec(1, 6, 0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 3, 2, 1, 0,  0, 0, 3, 3, 1);
    tbl[15] = vec(1, 6, 0, 0, 1, 0, 0, 0, 1,  0, 0, 0, 3, 2, 1, 0,  0, 0, 3, 3, 1);
    tbl[16] = vec(1, 6, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 3, 2, 1, 0,  0, 1, 3, 3, 1); // nob resumes
    tbl[17] = vec(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 2, 1, 0,  1, 0, 1, 4, 1);

    for (int k = 0; k < 2; k++) begin
      m_known[k] = 1'b0;
      m_dst[k][0] = 0; m_dst[k][1] = 0;
      m_state[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_err[k] = 0; m_run[k] = 0;
    end

    // Reset held for two cycles, then one idle cycle.
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      settle();
      check("reset pc_en", 32'(pc_en0), 32'd0);
      check("reset bubble", 32'(bubble0), 32'd1);
      check("reset ir_clr", 32'(ir_clr0), 32'd1);
      advance();
    end
    rst = 1'b0;
    settle();
    check("post-reset state", 32'(state0), 32'd0);
    check("post-reset stall_cnt", 32'(stall_cnt0), 32'd0);
    check("post-reset flush_cnt", 32'(flush_cnt0), 32'd0);
    check("post-reset err_stall", 32'(err0), 32'd0);
    check("post-reset nob err_stall", 32'(err1), 32'd0);
    advance();

    // Directed table.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].aa, tbl[i].ba, tbl[i].ma, tbl[i].mb, tbl[i].rw, tbl[i].da,
            tbl[i].br, tbl[i].mw);
      settle();
      check($sformatf("t%0d byp pc_en", i), 32'(pc_en0), 32'(tbl[i].p0));
      check($sformatf("t%0d byp bubble", i), 32'(bubble0), 32'(tbl[i].b0));
      check($sformatf("t%0d byp ir_clr", i), 32'(ir_clr0), 32'(tbl[i].c0));
      check($sformatf("t%0d byp state", i), 32'(state0), 32'(tbl[i].s0));
      check($sformatf("t%0d byp stall_cnt", i), 32'(stall_cnt0), 32'(tbl[i].sc0));
      check($sformatf("t%0d byp flush_cnt", i), 32'(flush_cnt0), 32'(tbl[i].fc0));
      check($sformatf("t%0d byp err_stall", i), 32'(err0), 32'(tbl[i].e0));
      check($sformatf("t%0d nob pc_en", i), 32'(pc_en1), 32'(tbl[i].p1));
      check($sformatf("t%0d nob bubble", i), 32'(bubble1), 32'(tbl[i].b1));
      check($sformatf("t%0d nob state", i), 32'(state1), 32'(tbl[i].s1));
      check($sformatf("t%0d nob stall_cnt", i), 32'(stall_cnt1), 32'(tbl[i].sc1));
      check($sformatf("t%0d nob err_stall", i), 32'(err1), 32'(tbl[i].e1));
      advance();
    end

    // Reset during a live hazard overrides the stall and clears everything.
    drive(1, 0, 0, 1, 1, 1, 2, 0, 0);
    settle();
    advance();
    drive(1, 2, 0, 0, 1, 0, 0, 0, 0);
    rst = 1'b1;
    settle();
    check("rst-mid-stall pc_en", 32'(pc_en0), 32'd0);
    check("rst-mid-stall bubble", 32'(bubble0), 32'd1);
    check("rst-mid-stall ir_clr", 32'(ir_clr0), 32'd1);
    advance();
    rst = 1'b0;
    settle();
    check("after rst scoreboard clear pc_en", 32'(pc_en0), 32'd1);
    check("after rst nob scoreboard clear pc_en", 32'(pc_en1), 32'd1);
    check("after rst nob err_stall", 32'(err1), 32'd0);
    check("after rst stall_cnt", 32'(stall_cnt0), 32'd0);
    check("after rst flush_cnt", 32'(flush_cnt0), 32'd0);
    advance();

    // Random stimulus against the model. Small address ranges make hazards frequent.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
            3'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      settle();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
